// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop line sync, 16x oversampling, byte holding register with valid/ack.
// Optional even-parity bit and parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx #(
   parameter int unsigned BAUD_DIV = 27
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   input  logic       rx_ack_i,
   output logic [7:0] dout_o,
   output logic       rx_valid_o,
   output logic       rx_done_o,
   output logic       frame_err_o,
`ifdef UART_RX_PARITY_EN
   output logic       parity_err_o,
`endif
   output logic       overrun_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   localparam logic [11:0] TICK_MAX = 12'(BAUD_DIV - 1);

   state_e      state_q;
   logic        rx_meta_q, rx_s_q;
   logic [11:0] tick_cnt_q, tick_cnt_d;
   logic        tick;
   logic [3:0]  os_cnt_q;
   logic [2:0]  bit_cnt_q;
   logic [7:0]  shift_q;
   logic [7:0]  dout_q;
   logic        rx_valid_q, rx_done_q, frame_err_q, overrun_q;
`ifdef UART_RX_PARITY_EN
   logic        parity_q, parity_err_q;
`endif

   // Both flops reset high so reset release never looks like a start bit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_comb begin
      tick       = (state_q != S_IDLE) && (tick_cnt_q == TICK_MAX);
      tick_cnt_d = (state_q == S_IDLE || tick) ? 12'd0 : tick_cnt_q + 12'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) tick_cnt_q <= 12'd0;
      else         tick_cnt_q <= tick_cnt_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         os_cnt_q     <= 4'd0;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'd0;
         dout_q       <= 8'd0;
         rx_valid_q   <= 1'b0;
         rx_done_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_q     <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         if (rx_ack_i) begin
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
         end
         if (tick) os_cnt_q <= os_cnt_q + 4'd1;

         case (state_q)
            S_IDLE: begin
               os_cnt_q <= 4'd0;
               if (!rx_s_q) state_q <= S_START;
            end
            S_START: begin
               if (tick && os_cnt_q == 4'd7) begin
                  os_cnt_q  <= 4'd0;
                  bit_cnt_q <= 3'd0;
                  state_q   <= rx_s_q ? S_IDLE : S_DATA;
               end
            end
            // os_cnt wraps 15 -> 0 on the sampling tick, so each bit is sampled mid-period.
            S_DATA: begin
               if (tick && os_cnt_q == 4'd15) begin
                  shift_q   <= {rx_s_q, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                  if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
`else
                  if (bit_cnt_q == 3'd7) state_q <= S_STOP;
`endif
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (tick && os_cnt_q == 4'd15) begin
                  parity_q <= rx_s_q;
                  state_q  <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (tick && os_cnt_q == 4'd15) begin
                  state_q <= S_IDLE;
                  if (rx_s_q) begin
                     dout_q     <= shift_q;
                     rx_done_q  <= 1'b1;
                     rx_valid_q <= 1'b1;
                     if (rx_valid_q && !rx_ack_i) overrun_q <= 1'b1;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
`ifdef UART_RX_PARITY_EN
                  parity_err_q <= parity_q ^ (^shift_q);
`endif
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dout_o      = dout_q;
   assign rx_valid_o  = rx_valid_q;
   assign rx_done_o   = rx_done_q;
   assign frame_err_o = frame_err_q;
   assign overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level model of the holding register, checked every cycle.
module tb_uart_rx;
   localparam int BD  = 4;
   localparam int BIT = 16 * BD;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 611 + BIT;
`else
   localparam int LAT = 611;
`endif

   logic clk = 1'b0, rst_n = 1'b1, rx = 1'b1, rx_ack = 1'b0;
   logic [7:0] dout;
   logic rx_valid, rx_done, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
   logic parity_err;
`endif

   int total = 0, bad = 0;
   int cyc = 0, t0 = 0;
   int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0, last_done_cyc = 0;

   typedef struct {
      logic [7:0] b;
      logic       stop;
      logic       par;
   } frm_t;
   frm_t q[$];

   logic [7:0] exp_dout = 8'h00;
   logic exp_valid = 1'b0, exp_ovr = 1'b0, ack_pend = 1'b0;

   uart_rx #(.BAUD_DIV(BD)) dut (
      .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .rx_ack_i(rx_ack),
      .dout_o(dout), .rx_valid_o(rx_valid), .rx_done_o(rx_done),
      .frame_err_o(frame_err),
`ifdef UART_RX_PARITY_EN
      .parity_err_o(parity_err),
`endif
      .overrun_o(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model: a frame queue plus the valid/overrun/ack rules of the holding register.
   always @(negedge clk) begin : cmp
      frm_t f;
      if (!rst_n) begin
         exp_dout = 8'h00; exp_valid = 1'b0; exp_ovr = 1'b0;
         q.delete();
         chk("rst_dout", 32'(dout), 32'(8'h00));
         chk("rst_valid", 32'(rx_valid), 32'(1'b0));
         chk("rst_done", 32'(rx_done), 32'(1'b0));
         chk("rst_ferr", 32'(frame_err), 32'(1'b0));
         chk("rst_ovr", 32'(overrun), 32'(1'b0));
      end else begin
         chk("done_ferr_excl", 32'(rx_done & frame_err), 32'(1'b0));
         if (rx_done || frame_err) begin
            if (rx_done) begin done_cnt++; last_done_cyc = cyc; end
            if (frame_err) ferr_cnt++;
            if (q.size() == 0) chk("unexpected_frame_event", 32'(1), 32'(0));
            else begin
               f = q.pop_front();
               chk("stop_bit_class", 32'(rx_done), 32'(f.stop));
`ifdef UART_RX_PARITY_EN
               chk("parity_err", 32'(parity_err), 32'(^{f.b, f.par}));
`endif
               if (rx_done) begin
                  exp_ovr   = ack_pend ? 1'b0 : (exp_ovr | exp_valid);
                  exp_valid = 1'b1;
                  exp_dout  = f.b;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         else chk("parity_quiet", 32'(parity_err), 32'(1'b0));
         if (parity_err) perr_cnt++;
`endif
         if (!rx_done && ack_pend) begin
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
         end
         chk("dout", 32'(dout), 32'(exp_dout));
         chk("rx_valid", 32'(rx_valid), 32'(exp_valid));
         chk("overrun", 32'(overrun), 32'(exp_ovr));
      end
      ack_pend = rx_ack;
   end

   task automatic drive(input logic v);
      rx = v;
      repeat (BIT) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic stop, input logic par);
      frm_t f;
      f.b = b; f.stop = stop; f.par = par;
      q.push_back(f);
      t0 = cyc;
      drive(1'b0);
      for (int i = 0; i < 8; i++) drive(b[i]);
`ifdef UART_RX_PARITY_EN
      drive(par);
`endif
      drive(stop);
      rx = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("frame_consumed", 32'(q.size()), 32'(0));
   endtask

   task automatic ack1();
      rx_ack = 1'b1;
      @(posedge clk); #1;
      rx_ack = 1'b0;
   endtask

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog: cycle budget exhausted at cyc %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      #2 rst_n = 1'b0;
      repeat (4) @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk); #1;

      // Bad stop bit: error pulse only, register untouched.
      send(8'h3C, 1'b0, 1'b0);
      chk("ferr_count", 32'(ferr_cnt), 32'(1));
      chk("ferr_dout", 32'(dout), 32'(8'h00));
      chk("ferr_valid", 32'(rx_valid), 32'(1'b0));

      // Short low glitch is rejected at start validation.
      rx = 1'b0;
      repeat (20) @(posedge clk); #1;
      rx = 1'b1;
      repeat (60) @(posedge clk); #1;
      chk("glitch_no_done", 32'(done_cnt), 32'(0));
      chk("glitch_dout", 32'(dout), 32'(8'h00));

      send(8'hA5, 1'b1, 1'b0);
      chk("a5_dout", 32'(dout), 32'(8'hA5));
      chk("a5_valid", 32'(rx_valid), 32'(1'b1));
      chk("a5_done_cnt", 32'(done_cnt), 32'(1));
      chk("a5_latency", 32'(last_done_cyc - t0), 32'(LAT));
      ack1();
      chk("ack_valid", 32'(rx_valid), 32'(1'b0));

      send(8'h11, 1'b1, 1'b0);
      send(8'h22, 1'b1, 1'b0);
      chk("ovr_dout", 32'(dout), 32'(8'h22));
      chk("ovr_set", 32'(overrun), 32'(1'b1));
      ack1();
      chk("ovr_ack_valid", 32'(rx_valid), 32'(1'b0));
      chk("ovr_ack_clr", 32'(overrun), 32'(1'b0));

      // Ack landing on the accept edge: the new byte stays valid, no overrun.
      send(8'h33, 1'b1, 1'b0);
      fork
         send(8'h44, 1'b1, 1'b0);
         begin
            repeat (LAT - 1) @(posedge clk); #1;
            rx_ack = 1'b1;
            @(posedge clk); #1;
            rx_ack = 1'b0;
         end
      join
      chk("ackacc_dout", 32'(dout), 32'(8'h44));
      chk("ackacc_valid", 32'(rx_valid), 32'(1'b1));
      chk("ackacc_ovr", 32'(overrun), 32'(1'b0));
      ack1();

      // Reset in the middle of bit 4 of 0xFF discards the frame.
      rx = 1'b0;
      repeat (BIT) @(posedge clk); #1;
      rx = 1'b1;
      repeat (4 * BIT + BIT / 2) @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk); #1;
      chk("midrst_dout", 32'(dout), 32'(8'h00));
      chk("midrst_valid", 32'(rx_valid), 32'(1'b0));
      send(8'h5A, 1'b1, 1'b0);
      chk("post_rst_dout", 32'(dout), 32'(8'h5A));
      chk("post_rst_valid", 32'(rx_valid), 32'(1'b1));
      chk("post_rst_ovr", 32'(overrun), 32'(1'b0));
      chk("post_rst_ferr", 32'(ferr_cnt), 32'(1));
      ack1();

`ifdef UART_RX_PARITY_EN
      send(8'h07, 1'b1, 1'b1);
      chk("par_ok_cnt", 32'(perr_cnt), 32'(0));
      ack1();
      send(8'h07, 1'b1, 1'b0);
      chk("par_bad_cnt", 32'(perr_cnt), 32'(1));
      chk("par_bad_dout", 32'(dout), 32'(8'h07));
      chk("par_bad_valid", 32'(rx_valid), 32'(1'b1));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver that sits directly downstream of the transmitter on the serial line and recovers the 8N1 frames it produces. It synchronises the asynchronous line, detects and validates the start bit with a 16x oversampling tick generated internally, shifts in 8 data bits LSB first, checks the stop bit, and presents the byte in a holding register with a valid/acknowledge handshake toward the consuming logic.

## Interface
- BAUD_DIV, 27: clk cycles per oversample tick; bit period = 16*BAUD_DIV clk. Legal range 2..4095. 27 gives 115200 baud from 50 MHz.
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_ack  input  1  consumer acknowledge; clears rx_valid and overrun.
- dout  output  8  last received byte.
- rx_valid  output  1  dout holds an unacknowledged byte.
- rx_done  output  1  one-clk pulse per accepted frame.
- frame_err  output  1  one-clk pulse when the stop bit samples 0.
- overrun  output  1  sticky: a frame was accepted while rx_valid was already 1.

## Operation
- rx passes through a 2-flop synchroniser (both flops reset to 1); all logic uses the synchronised value rx_s.
- Tick counter: 12 bits, counts 0..BAUD_DIV-1, tick = 1 on the cycle count == BAUD_DIV-1, then wraps to 0. Held at 0 in IDLE; runs in all other states.
- Oversample counter os_cnt (4 bits), advances on tick, wraps 15 -> 0. Bit counter bit_cnt (3 bits).
- States:
  - IDLE: rx_s == 0 -> START, os_cnt = 0, tick counter = 0.
  - START: on tick with os_cnt == 7, sample rx_s: 0 -> DATA (os_cnt = 0, bit_cnt = 0); 1 -> IDLE (glitch rejected, no outputs change).
  - DATA: on tick with os_cnt == 15 (mid-bit), shift rx_s into shift register MSB, shifting right; bit_cnt == 7 -> next state (PARITY if enabled, else STOP), else bit_cnt + 1.
  - STOP: on tick with os_cnt == 15, sample rx_s. 1: dout <= shift register, rx_done pulse, rx_valid <= 1, overrun <= 1 if rx_valid was already 1 and rx_ack is not high that cycle. 0: frame_err pulse, dout and rx_valid unchanged. Either way -> IDLE.
- rx_ack high clears rx_valid and overrun on the next edge. rx_ack on the same cycle as an accept: accept wins (rx_valid = 1, overrun not set).
- Overrun overwrites dout with the newer byte.
- Reset: asynchronous; all state, counters and outputs return to reset values mid-frame; the partial frame is discarded.

## Timing
- Reset values: dout = 0x00, rx_valid = 0, rx_done = 0, frame_err = 0, overrun = 0, state IDLE.
- Start detection: 2 clk after rx falls (synchroniser).
- Start validated 8*BAUD_DIV clk after detection; each data bit sampled 16*BAUD_DIV clk apart.
- rx_done/frame_err/dout/rx_valid update on the clk edge following the stop-sample tick; rx_done and frame_err are exactly 1 clk wide.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start bit immediately after the stop bit is caught.

## Configuration
- UART_RX_PARITY_EN: when defined, a PARITY state between DATA and STOP samples a 9th bit at os_cnt == 15; an output parity_err (1 bit, reset 0) pulses for 1 clk at the stop-sample cycle if the XOR of data and parity bits is 1 (even parity). The byte is still written to dout and rx_valid still set. Without the macro: no PARITY state, no parity_err port; frame is 8N1.

## Test plan
- BAUD_DIV = 4 (bit = 64 clk): send 0xA5 8N1 -> dout = 0xA5, rx_done one pulse, rx_valid = 1, frame_err = 0.
- Low glitch of 20 clk on idle line -> returns to IDLE, no rx_done, dout unchanged.
- Frame 0x3C with stop bit 0 -> frame_err one pulse, rx_valid stays 0, dout = 0x00.
- Send 0x11 then 0x22 without rx_ack -> dout = 0x22, overrun = 1; rx_ack for 1 clk -> rx_valid = 0, overrun = 0.
- Drive rst low during bit 4 of 0xFF, release, send 0x5A -> dout = 0x5A, no error.
- With UART_RX_PARITY_EN: send 0x07 with parity 1 -> parity_err = 0; with parity 0 -> parity_err pulse, dout = 0x07.
